// File: rtl/mod_addsub_ctrl.sv
// mod_addsub_ctrl: modular add/subtract sequencer driving the multi-precision
// adder over its start/subtract/done handshake. Computes (a+b) mod m or
// (a-b) mod m with one or two adder transactions.
// Optional feature: define MODADDSUB_WATCHDOG_EN to build a per-transaction
// watchdog that aborts a WAIT state after TIMEOUT cycles with err=1, result=0.
module mod_addsub_ctrl #(
  parameter int unsigned W       = 1027,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_m,
  output logic [W-1:0] result,
  output logic         done,
  output logic         busy,
  output logic         err,
  output logic         add_start,
  output logic         add_subtract,
  output logic [W-1:0] add_in_a,
  output logic [W-1:0] add_in_b,
  input  logic [W:0]   add_result,
  input  logic         add_done
);

  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("mod_addsub_ctrl: TIMEOUT must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE1,
    S_WAIT1,
    S_ISSUE2,
    S_WAIT2,
    S_FIN
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic         sub_q, sub_d;
  logic [W-1:0] result_q, result_d;
  logic         done_q, done_d;
  logic         busy_q, busy_d;
  logic         add_start_q, add_start_d;
  logic         add_subtract_q, add_subtract_d;
  logic [W-1:0] add_in_a_q, add_in_a_d;
  logic [W-1:0] add_in_b_q, add_in_b_d;

`ifdef MODADDSUB_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            err_q, err_d;
`endif

  // Next-state and next-output logic. Outputs are computed one cycle ahead
  // so every port comes straight from a flop. The first adder result r is
  // kept in add_in_a (it is the second transaction's operand and must stay
  // stable anyway), so WAIT2 selects between add_in_a_q and the new result.
  always_comb begin
    state_d        = state_q;
    m_d            = m_q;
    sub_d          = sub_q;
    result_d       = result_q;
    done_d         = 1'b0;
    busy_d         = busy_q;
    add_start_d    = 1'b0;
    add_subtract_d = add_subtract_q;
    add_in_a_d     = add_in_a_q;
    add_in_b_d     = add_in_b_q;
`ifdef MODADDSUB_WATCHDOG_EN
    wd_cnt_d       = '0;
    err_d          = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_ISSUE1;
          m_d            = in_m;
          sub_d          = op_sub;
          add_in_a_d     = in_a;
          add_in_b_d     = in_b;
          add_subtract_d = op_sub;
          add_start_d    = 1'b1;
          busy_d         = 1'b1;
        end
      end
      S_ISSUE1: state_d = S_WAIT1;
      S_WAIT1: begin
        if (add_done) begin
          if (sub_q && !add_result[W]) begin
            result_d = add_result[W-1:0];
            done_d   = 1'b1;
            state_d  = S_FIN;
          end else begin
            add_in_a_d     = add_result[W-1:0];
            add_in_b_d     = m_q;
            add_subtract_d = ~sub_q;
            add_start_d    = 1'b1;
            state_d        = S_ISSUE2;
          end
        end
      end
      S_ISSUE2: state_d = S_WAIT2;
      S_WAIT2: begin
        if (add_done) begin
          result_d = (!sub_q && add_result[W]) ? add_in_a_q : add_result[W-1:0];
          done_d   = 1'b1;
          state_d  = S_FIN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef MODADDSUB_WATCHDOG_EN
    if ((state_q == S_WAIT1 || state_q == S_WAIT2) && !add_done) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
        result_d = '0;
        done_d   = 1'b1;
        err_d    = 1'b1;
        state_d  = S_FIN;
      end
    end
`endif
  end

  // State and registered outputs; synchronous active-low reset clears all.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      m_q            <= '0;
      sub_q          <= 1'b0;
      result_q       <= '0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      add_start_q    <= 1'b0;
      add_subtract_q <= 1'b0;
      add_in_a_q     <= '0;
      add_in_b_q     <= '0;
    end else begin
      state_q        <= state_d;
      m_q            <= m_d;
      sub_q          <= sub_d;
      result_q       <= result_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      add_start_q    <= add_start_d;
      add_subtract_q <= add_subtract_d;
      add_in_a_q     <= add_in_a_d;
      add_in_b_q     <= add_in_b_d;
    end
  end

`ifdef MODADDSUB_WATCHDOG_EN
  // Watchdog counter (cleared outside WAIT states, i.e. at every add_start).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign result       = result_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign add_start    = add_start_q;
  assign add_subtract = add_subtract_q;
  assign add_in_a     = add_in_a_q;
  assign add_in_b     = add_in_b_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Self-checking bench for mod_addsub_ctrl: randomized modular add/sub
// operations against a behavioural reference, with a latency-2 adder model.
module tb_mod_addsub_ctrl;
  localparam int unsigned W       = 1027;
  localparam int unsigned TIMEOUT = 16;
  localparam int          L       = 2;

  typedef logic [W-1:0] wide_t;
  typedef logic [W:0]   wide1_t;

  logic   clk = 1'b0;
  logic   resetn = 1'b0;
  logic   start = 1'b0;
  logic   op_sub = 1'b0;
  wide_t  in_a = '0, in_b = '0, in_m = '0;
  wide_t  result, add_in_a, add_in_b;
  logic   done, busy, err, add_start, add_subtract;
  wide1_t add_result = '0;
  logic   add_done = 1'b0;

  mod_addsub_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op_sub(op_sub),
    .in_a(in_a), .in_b(in_b), .in_m(in_m),
    .result(result), .done(done), .busy(busy), .err(err),
    .add_start(add_start), .add_subtract(add_subtract),
    .add_in_a(add_in_a), .add_in_b(add_in_b),
    .add_result(add_result), .add_done(add_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Driver-owned controls read by the model.
  bit    adder_en = 1'b1;
  bit    pin_en = 1'b0;
  wide_t pin_res = '0;
  int    pin_lat = 0;

  task automatic chkw(input string name, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (low 160 bits) cycle %0d",
               name, act[159:0], exp[159:0], cyc);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic wide_t rand_wide();
    wide_t v = '0;
    for (int i = 0; i < int'((W + 31) / 32); i++) v = {v[W-33:0], $urandom()};
    return v;
  endfunction

  function automatic wide_t model_result(input wide_t a, input wide_t b,
                                         input wide_t m, input logic s);
    wide1_t x;
    if (!s) begin
      x = {1'b0, a} + {1'b0, b};
      if (x >= {1'b0, m}) x = x - {1'b0, m};
      return x[W-1:0];
    end
    if (a >= b) return a - b;
    return a + (m - b);
  endfunction

  // Reference model, compare process and adder model in one process.
  bit    have_op = 1'b0, op_two = 1'b0, op_ok = 1'b0, op_err = 1'b0;
  bit    op_pin = 1'b0, rst_seen = 1'b0, pend = 1'b0, act = 1'b0;
  bit    edone = 1'b0, est = 1'b0;
  logic  op_s = 1'b0, ls = 1'b0;
  int    op_t = 0, op_done = 0, op_pl = 0, pend_cyc = 0;
  wide_t op_res = '0, op_pr = '0, exp_res = '0, t1a = '0, t1b = '0;
  wide_t t2a = '0, op_m = '0, la = '0, lb = '0;

  initial begin : model
    forever begin
      @(posedge clk);
      rst_seen = !resetn;
      if (!resetn) begin
        have_op = 1'b0;
        exp_res = '0;
        pend    = 1'b0;
      end else if (start && !(have_op && cyc <= op_done)) begin
        have_op = 1'b1;
        op_t    = cyc;
        op_s    = op_sub;
        op_m    = in_m;
        op_ok   = adder_en;
        t1a     = in_a;
        t1b     = in_b;
        t2a     = op_sub ? in_a - in_b : in_a + in_b;
        op_res  = model_result(in_a, in_b, in_m, op_sub);
        op_two  = op_ok && (!op_sub || in_a < in_b);
        op_err  = 1'b0;
        op_pin  = pin_en;
        op_pr   = pin_res;
        op_pl   = pin_lat;
        if (op_ok) op_done = op_two ? cyc + 3 + 2 * L : cyc + 2 + L;
        else begin
`ifdef MODADDSUB_WATCHDOG_EN
          op_done = cyc + 2 + int'(TIMEOUT);
          op_res  = '0;
          op_err  = 1'b1;
`else
          op_done = 32'h7fff_ffff;
`endif
        end
      end
      cyc++;

      @(negedge clk);
      act   = have_op && cyc > op_t && cyc <= op_done;
      edone = have_op && cyc == op_done;
      if (edone) exp_res = op_res;
      chki("busy", int'(busy), int'(act));
      chki("done", int'(done), int'(edone));
      chki("err", int'(err), int'(edone && op_err));
      chkw("result", result, exp_res);
      est = have_op && (cyc == op_t + 1 || (op_two && cyc == op_t + 2 + L));
      chki("add_start", int'(add_start), int'(est));
      if (add_start && est) begin
        if (cyc == op_t + 1) begin
          chkw("txn1_in_a", add_in_a, t1a);
          chkw("txn1_in_b", add_in_b, t1b);
          chki("txn1_subtract", int'(add_subtract), int'(op_s));
        end else begin
          chkw("txn2_in_a", add_in_a, t2a);
          chkw("txn2_in_b", add_in_b, op_m);
          chki("txn2_subtract", int'(add_subtract), int'(!op_s));
        end
      end
      if (edone && op_pin) begin
        chkw("pinned_result", result, op_pr);
        chki("pinned_latency", cyc - op_t, op_pl);
      end
      if (rst_seen) begin
        chkw("reset_add_in_a", add_in_a, '0);
        chkw("reset_add_in_b", add_in_b, '0);
        chki("reset_add_subtract", int'(add_subtract), 0);
      end

      // Adder model: fixed latency L, checks operand stability up to done.
      add_done = 1'b0;
      if (add_start && adder_en && !rst_seen) begin
        pend     = 1'b1;
        pend_cyc = cyc + L;
        la       = add_in_a;
        lb       = add_in_b;
        ls       = add_subtract;
      end
      if (pend && cyc == pend_cyc) begin
        pend = 1'b0;
        chkw("hold_in_a", add_in_a, la);
        chkw("hold_in_b", add_in_b, lb);
        chki("hold_subtract", int'(add_subtract), int'(ls));
        add_done   = 1'b1;
        add_result = ls ? {1'b0, la} - {1'b0, lb} : {1'b0, la} + {1'b0, lb};
      end else if (!pend && !act && $urandom_range(0, 3) == 0) begin
        add_done   = 1'b1;
        add_result = {1'b1, rand_wide()};
      end
    end
  end

  task automatic run_op(input wide_t a, input wide_t b, input wide_t m,
                        input logic s, input bit pe, input wide_t pr,
                        input int pl, input bit noise);
    @(negedge clk);
    pin_en  = pe;
    pin_res = pr;
    pin_lat = pl;
    start   = 1'b1;
    op_sub  = s;
    in_a    = a;
    in_b    = b;
    in_m    = m;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start  = noise && ($urandom_range(0, 5) == 0);
      in_a   = rand_wide();
      in_b   = rand_wide();
      in_m   = rand_wide();
      op_sub = 1'($urandom_range(0, 1));
      if (done) break;
    end
    start  = 1'b0;
    pin_en = 1'b0;
  endtask

  initial begin : driver
    wide_t a, b, m;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run_op(700, 500, 1000, 1'b0, 1'b1, 200, 7, 1'b0);
    run_op(300, 400, 1000, 1'b0, 1'b1, 700, 7, 1'b0);
    run_op(900, 100, 1000, 1'b1, 1'b1, 800, 4, 1'b0);
    run_op(100, 900, 1000, 1'b1, 1'b1, 200, 7, 1'b0);
    run_op(400, 600, 1000, 1'b0, 1'b1, 0, 7, 1'b0);
    run_op(5, 5, 1000, 1'b1, 1'b1, 0, 4, 1'b0);
    m = '1;
    m = m >> 2;
    run_op(m - 1, m - 1, m, 1'b0, 1'b1, m - 2, 7, 1'b1);
    run_op('0, m - 1, m, 1'b1, 1'b1, 1, 7, 1'b1);

    // Extra start in WAIT1, then reset during WAIT2.
    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; in_a = 700; in_b = 500; in_m = 1000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; in_a = 5; in_b = 6; in_m = 7; op_sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    run_op(123, 456, 1000, 1'b0, 1'b1, 579, 7, 1'b0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) m = wide_t'($urandom_range(2, 2000));
      else m = rand_wide() >> $urandom_range(1, W - 2);
      if (m < wide_t'(2)) m = wide_t'(2);
      case ($urandom_range(0, 5))
        0:       a = '0;
        1:       a = m - 1;
        default: a = rand_wide() % m;
      endcase
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = m - 1;
        default: b = rand_wide() % m;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(a, b, m, 1'($urandom_range(0, 1)), 1'b0, '0, 0, 1'b1);
    end

    // Adder never answers.
    adder_en = 1'b0;
`ifdef MODADDSUB_WATCHDOG_EN
    run_op(1, 2, 1000, 1'b0, 1'b1, 0, 2 + int'(TIMEOUT), 1'b0);
`else
    run_op(1, 2, 1000, 1'b0, 1'b0, '0, 0, 1'b0);
`endif
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn   = 1'b1;
    adder_en = 1'b1;
    run_op(1, 2, 10, 1'b0, 1'b1, 3, 7, 1'b0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
